// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point add/sub datapath:
// FSM state encoding, status-flag layout and exponent-field helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_HOLD
  } fp_state_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic zero;
  } fp_flags_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned fp_exp_ones(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Final rounding stage: turns a normalised {frac, G, R, S} word and exponent into
// the packed fraction/exponent. FP_ROUND_RNE_EN selects round-to-nearest-even, else truncate.
module fp_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic [MAN_W+2:0] frac_grs_i,
  input  logic [EXP_W:0]   exp_i,
  output logic [MAN_W-1:0] frac_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             inexact_o,
  output logic             overflow_o
);

  localparam int unsigned EXP_MAX = fp_exp_ones(EXP_W);

  logic [MAN_W:0] frac_ext;
  logic [EXP_W:0] exp_r;
  logic           round_up;

  always_comb begin
    round_up = 1'b0;
`ifdef FP_ROUND_RNE_EN
    round_up = frac_grs_i[2] & (frac_grs_i[1] | frac_grs_i[0] | frac_grs_i[3]);
`endif
    // A carry out of the fraction means 1.111..1 rounded to 10.000..0: bump the exponent.
    frac_ext   = {1'b0, frac_grs_i[MAN_W+2:3]} + {{MAN_W{1'b0}}, round_up};
    exp_r      = exp_i + {{EXP_W{1'b0}}, frac_ext[MAN_W]};
    overflow_o = 32'(exp_r) >= EXP_MAX;
    inexact_o  = (|frac_grs_i[2:0]) | overflow_o;
    frac_o     = overflow_o ? '0 : frac_ext[MAN_W-1:0];
    exp_o      = overflow_o ? {EXP_W{1'b1}} : exp_r[EXP_W-1:0];
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle parametrised floating-point adder/subtractor (bfloat16 by default).
// Rounding: round-to-nearest-even when FP_ROUND_RNE_EN is defined, truncation otherwise.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 7,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic [3:0]   flags,
  output fp_state_e    dbg_state_o
);

  // Handshake: a transfer happens on a rising clock edge where valid and ready are both
  // high. in_ready is high only in IDLE, out_valid only in HOLD; sum/flags hold until taken.

  // Working mantissa layout: {carry, hidden, frac[MAN_W-1:0], G, R, S}.
  localparam int M = MAN_W + 5;
  localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};

  fp_state_e      state_q;
  logic           in_ready_q, out_valid_q;
  logic [W-1:0]   sum_q;
  fp_flags_t      flags_q;
  logic [EXP_W:0] ea_q, eb_q, e_q;
  logic [M-1:0]   ma_q, mb_q, m_q;
  logic           sa_q, sb_q, s_q;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic             a_zero, b_zero, b_sign;
  logic             a_gt;
  logic [EXP_W:0]   diff;
  logic             collapse;

  logic [MAN_W-1:0] rnd_frac;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_inexact, rnd_ovf;

  function automatic logic [M-1:0] shr1(input logic [M-1:0] m);
    return {1'b0, m[M-1:2], m[1] | m[0]};
  endfunction

  assign a_exp  = a[W-2:MAN_W];
  assign b_exp  = b[W-2:MAN_W];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign b_sign = b[W-1] ^ sub;

  assign a_gt     = ea_q > eb_q;
  assign diff     = a_gt ? (ea_q - eb_q) : (eb_q - ea_q);
  assign collapse = 32'(diff) > MAN_W + 3;

  fp_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .frac_grs_i (m_q[MAN_W+2:0]),
    .exp_i      (e_q),
    .frac_o     (rnd_frac),
    .exp_o      (rnd_exp),
    .inexact_o  (rnd_inexact),
    .overflow_o (rnd_ovf)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      e_q         <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      m_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      s_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            ea_q       <= {1'b0, a_exp};
            eb_q       <= {1'b0, b_exp};
            ma_q       <= {2'b01, a[MAN_W-1:0], 3'b000};
            mb_q       <= {2'b01, b[MAN_W-1:0], 3'b000};
            sa_q       <= a[W-1];
            sb_q       <= b_sign;
            if (a_zero | b_zero) begin
              // Zero exponent means zero (denormals flushed): pass the other operand through.
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              if (a_zero & b_zero) begin
                sum_q   <= {a[W-1] & b_sign, {(W-1){1'b0}}};
                flags_q <= '{overflow: 1'b0, underflow: 1'b0, inexact: 1'b0, zero: 1'b1};
              end else begin
                sum_q   <= a_zero ? {b_sign, b[W-2:0]} : a;
                flags_q <= '0;
              end
            end else begin
              state_q <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (ea_q == eb_q) begin
            state_q <= ST_ADD;
          end else if (a_gt) begin
            eb_q <= collapse ? ea_q : eb_q + E_ONE;
            mb_q <= collapse ? {{(M-1){1'b0}}, |mb_q} : shr1(mb_q);
          end else begin
            ea_q <= collapse ? eb_q : ea_q + E_ONE;
            ma_q <= collapse ? {{(M-1){1'b0}}, |ma_q} : shr1(ma_q);
          end
        end
        ST_ADD: begin
          e_q     <= ea_q;
          state_q <= ST_NORM;
          if (sa_q == sb_q) begin
            m_q <= ma_q + mb_q;
            s_q <= sa_q;
          end else if (ma_q == mb_q) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
            sum_q       <= '0;
            flags_q     <= '{overflow: 1'b0, underflow: 1'b0, inexact: 1'b0, zero: 1'b1};
          end else if (ma_q > mb_q) begin
            m_q <= ma_q - mb_q;
            s_q <= sa_q;
          end else begin
            m_q <= mb_q - ma_q;
            s_q <= sb_q;
          end
        end
        ST_NORM: begin
          if (m_q[M-1]) begin
            m_q     <= shr1(m_q);
            e_q     <= e_q + E_ONE;
            state_q <= ST_ROUND;
          end else if (!m_q[M-2]) begin
            if (e_q == E_ONE) begin
              // The next left shift would take the exponent to 0: flush to signed zero.
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              sum_q       <= {s_q, {(W-1){1'b0}}};
              flags_q     <= '{overflow: 1'b0, underflow: 1'b1, inexact: 1'b1, zero: 1'b0};
            end else begin
              m_q <= m_q << 1;
              e_q <= e_q - E_ONE;
            end
          end else begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
          sum_q       <= {s_q, rnd_exp, rnd_frac};
          flags_q     <= '{overflow: rnd_ovf, underflow: 1'b0, inexact: rnd_inexact, zero: 1'b0};
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign sum         = sum_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq (bfloat16 defaults): directed cases, handshake/reset checks and
// random operations against an integer-arithmetic reference model.
module tb_fp_addsub_seq;
  import fp_pkg::*;

  logic        clock = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic [3:0]  flags;
  fp_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] exp_q[$];

`ifdef FP_ROUND_RNE_EN
  localparam logic [15:0] TIE_ODD_SUM = 16'h3F82;
`else
  localparam logic [15:0] TIE_ODD_SUM = 16'h3F81;
`endif

  always #5 clock = ~clock;

  fp_addsub_seq dut (
    .clock       (clock),
    .nreset      (nreset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .flags       (flags),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int sticky_shr(input int v, input int n);
    if (n >= 30) return (v != 0) ? 1 : 0;
    return (v >> n) | (((v & ((1 << n) - 1)) != 0) ? 1 : 0);
  endfunction

  // Returns {overflow, underflow, inexact, zero, sum}. Mantissas are integers scaled by 8
  // so the three low bits carry guard/round/sticky.
  function automatic logic [19:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic op_sub);
    int ex, ey, mx, my, e, m, frac, grs;
    logic sx, sy, s, up, inexact;
    ex = int'(x[14:7]);
    ey = int'(y[14:7]);
    sx = x[15];
    sy = y[15] ^ op_sub;
    if (ex == 0 && ey == 0) return {4'b0001, sx & sy, 15'd0};
    if (ex == 0) return {4'b0000, sy, y[14:0]};
    if (ey == 0) return {4'b0000, x};
    mx = (128 + int'(x[6:0])) * 8;
    my = (128 + int'(y[6:0])) * 8;
    if (ex >= ey) begin
      my = sticky_shr(my, ex - ey);
      e  = ex;
    end else begin
      mx = sticky_shr(mx, ey - ex);
      e  = ey;
    end
    if (sx == sy) begin
      m = mx + my;
      s = sx;
    end else if (mx == my) begin
      return {4'b0001, 16'h0000};
    end else if (mx > my) begin
      m = mx - my;
      s = sx;
    end else begin
      m = my - mx;
      s = sy;
    end
    if (m >= 2048) begin
      m = sticky_shr(m, 1);
      e = e + 1;
    end else begin
      while (m < 1024) begin
        e = e - 1;
        if (e == 0) return {4'b0110, s, 15'd0};
        m = m * 2;
      end
    end
    grs     = m % 8;
    frac    = (m / 8) % 128;
    inexact = (grs != 0);
`ifdef FP_ROUND_RNE_EN
    up = ((grs & 4) != 0) && (((grs & 3) != 0) || ((frac & 1) != 0));
`else
    up = 1'b0;
`endif
    if (up) frac = frac + 1;
    if (frac == 128) begin
      frac = 0;
      e    = e + 1;
    end
    if (e >= 255) return {4'b1010, s, 8'hFF, 7'h00};
    return {2'b00, inexact, 1'b0, s, 8'(e), 7'(frac)};
  endfunction

  // One complete transaction: issue, wait for the result (bounded), optionally stall the
  // consumer while pushing ignored traffic, then take the result.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                        input logic [19:0] expv, input int exp_lat, input int stall,
                        input bit noisy);
    int lat;
    logic [19:0] want;
    @(negedge clock);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb_v;
    sub      = ts;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    lat      = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    want = exp_q.pop_front();
    check("out_valid_timeout", 32'(out_valid), 32'd1);
    if (!out_valid) return;
    check("sum", 32'(sum), 32'(want[15:0]));
    check("flags", 32'(flags), 32'(want[19:16]));
    if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
    repeat (stall) begin
      if (noisy) begin
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        sub      = 1'($urandom);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (stall > 0) begin
      check("hold_sum", 32'(sum), 32'(want[15:0]));
      check("hold_flags", 32'(flags), 32'(want[19:16]));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("valid_clear", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ex, ey, d;
    logic [15:0] x, y;
    logic s;
    nreset    = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    nreset = 1'b1;

    run_op(16'h3F80, 16'h4000, 1'b0, {4'b0000, 16'h4040}, 5, 5, 1'b1);
    run_op(16'h4000, 16'h4000, 1'b0, {4'b0000, 16'h4080}, 4, 0, 1'b0);
    run_op(16'h3F80, 16'h3F80, 1'b1, {4'b0001, 16'h0000}, -1, 1, 1'b0);
    run_op(16'h3F81, 16'h3B80, 1'b0, {4'b0010, TIE_ODD_SUM}, -1, 0, 1'b0);
    run_op(16'h4380, 16'h3F80, 1'b0, {4'b0010, 16'h4380}, -1, 0, 1'b0);
    run_op(16'h7F7F, 16'h7F7F, 1'b0, {4'b1010, 16'h7F80}, -1, 2, 1'b1);
    run_op(16'h0000, 16'hC040, 1'b0, {4'b0000, 16'hC040}, 0, 0, 1'b0);
    run_op(16'h3F80, 16'h0000, 1'b1, {4'b0000, 16'h3F80}, -1, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, {4'b0001, 16'h8000}, -1, 0, 1'b0);
    run_op(16'h8000, 16'h0000, 1'b1, {4'b0001, 16'h8000}, -1, 0, 1'b0);
    run_op(16'h8000, 16'h0000, 1'b0, {4'b0001, 16'h0000}, -1, 0, 1'b0);
    run_op(16'h0055, 16'h3F80, 1'b1, {4'b0000, 16'hBF80}, -1, 0, 1'b0);
    run_op(16'h0100, 16'h00FF, 1'b1, {4'b0110, 16'h0000}, -1, 0, 1'b0);
    run_op(16'h3F80, 16'h4000, 1'b1, {4'b0000, 16'hBF80}, -1, 0, 1'b0);

    // Asynchronous reset while the operation is still aligning.
    @(negedge clock);
    a        = 16'h4380;
    b        = 16'h3F80;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    nreset = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_flags", 32'(flags), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    nreset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      ex = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 254));
      d  = int'($urandom_range(0, 14));
      ey = ($urandom_range(0, 1) == 0) ? ex - d : ex + d;
      if (ey < 0) ey = 0;
      if (ey > 255) ey = 255;
      if ($urandom_range(0, 15) == 0) ex = 0;
      x = {1'($urandom), 8'(ex), 7'($urandom)};
      y = {1'($urandom), 8'(ey), 7'($urandom)};
      s = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        y = x;
        s = 1'b1;
      end
      run_op(x, y, s, ref_op(x, y, s), -1, int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
